// File: rtl/knn_sample_fetcher_pkg.sv
// knn_sample_fetcher_pkg: FSM states and sample-layout helper shared by the KNN fetch path
package knn_sample_fetcher_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_IN, S_FETCH, S_PRESENT, S_WAIT, S_FIN} state_e;
  function automatic int sample_words(input int max_elements);
    return max_elements + 1;
  endfunction
endpackage

// File: rtl/knn_sample_fetcher.sv
// knn_sample_fetcher: loads the input vector, then streams packed training samples one per request
module knn_sample_fetcher
  import knn_sample_fetcher_pkg::*;
#(
  parameter int W            = 16,
  parameter int MAX_ELEMENTS = 32,
  parameter int TYPE_W       = 3,
  parameter int L            = 6,
  parameter int ADDR_W       = 16,
  parameter int INPUT_BASE   = 0,
  parameter int TRAIN_BASE   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      data_request,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [W-1:0]              mem_rd_data,
  input  logic                      mem_rd_valid,
  output logic [W*MAX_ELEMENTS-1:0] input_data,
  output logic [W*MAX_ELEMENTS-1:0] training_data,
  output logic [TYPE_W-1:0]         training_data_type,
  output logic                      read_done,
  output logic                      busy,
  output logic                      run_done
);
  localparam int SW = sample_words(MAX_ELEMENTS);
  localparam int WW = $clog2(SW);
  state_e state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [L-1:0] sample_q, sample_d;
  logic pending_q, pending_d, outstanding_q, outstanding_d;
  logic [W*MAX_ELEMENTS-1:0] input_data_q, input_data_d, shadow_q, shadow_d;
  logic [W*MAX_ELEMENTS-1:0] training_data_q, training_data_d;
  logic [TYPE_W-1:0] shadow_type_q, shadow_type_d, training_data_type_q, training_data_type_d;
  logic read_done_q, read_done_d, run_done_q, run_done_d, busy_q, busy_d;
  logic fill, last_word;
  always_comb begin
    state_d              = state_q;
    word_d               = word_q;
    sample_d             = sample_q;
    pending_d            = pending_q;
    outstanding_d        = outstanding_q;
    input_data_d         = input_data_q;
    shadow_d             = shadow_q;
    shadow_type_d        = shadow_type_q;
    training_data_d      = training_data_q;
    training_data_type_d = training_data_type_q;
    read_done_d          = 1'b0;
    run_done_d           = 1'b0;
    fill      = state_q == S_LOAD_IN || state_q == S_FETCH;
    last_word = state_q == S_LOAD_IN ? word_q == WW'(MAX_ELEMENTS - 1) : word_q == WW'(MAX_ELEMENTS);
    mem_rd_en = fill && !outstanding_q;
    mem_addr  = !mem_rd_en ? '0 :
                state_q == S_LOAD_IN ? ADDR_W'(INPUT_BASE) + ADDR_W'(word_q) :
                ADDR_W'(TRAIN_BASE) + ADDR_W'(sample_q) * ADDR_W'(SW) + ADDR_W'(word_q);
    if (data_request && (fill || state_q == S_PRESENT)) pending_d = 1'b1;
    case (state_q)
      S_IDLE: if (start && !run_done_q) begin
        state_d       = S_LOAD_IN;
        word_d        = '0;
        sample_d      = '0;
        pending_d     = 1'b0;
        outstanding_d = 1'b0;
      end
      S_LOAD_IN, S_FETCH: begin
        if (!outstanding_q) outstanding_d = 1'b1;
        else if (mem_rd_valid) begin
          outstanding_d = 1'b0;
          word_d        = last_word ? '0 : word_q + 1'b1;
          if (state_q == S_LOAD_IN) input_data_d[word_q*W +: W] = mem_rd_data;
          else if (!last_word) shadow_d[word_q*W +: W] = mem_rd_data;
          else shadow_type_d = mem_rd_data[TYPE_W-1:0];
          if (last_word) state_d = state_q == S_LOAD_IN ? S_FETCH : S_PRESENT;
        end
      end
      S_PRESENT: begin
        training_data_d      = shadow_q;
        training_data_type_d = shadow_type_q;
        read_done_d          = 1'b1;
        state_d              = &sample_q ? S_FIN : S_WAIT;
      end
      S_WAIT: if (data_request || pending_q) begin
        state_d   = S_FETCH;
        pending_d = 1'b0;
        sample_d  = sample_q + 1'b1;
      end
      S_FIN: begin
        run_done_d = 1'b1;
        pending_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= S_IDLE;
      word_q               <= '0;
      sample_q             <= '0;
      pending_q            <= 1'b0;
      outstanding_q        <= 1'b0;
      input_data_q         <= '0;
      shadow_q             <= '0;
      shadow_type_q        <= '0;
      training_data_q      <= '0;
      training_data_type_q <= '0;
      read_done_q          <= 1'b0;
      run_done_q           <= 1'b0;
      busy_q               <= 1'b0;
    end else begin
      state_q              <= state_d;
      word_q               <= word_d;
      sample_q             <= sample_d;
      pending_q            <= pending_d;
      outstanding_q        <= outstanding_d;
      input_data_q         <= input_data_d;
      shadow_q             <= shadow_d;
      shadow_type_q        <= shadow_type_d;
      training_data_q      <= training_data_d;
      training_data_type_q <= training_data_type_d;
      read_done_q          <= read_done_d;
      run_done_q           <= run_done_d;
      busy_q               <= busy_d;
    end
  end
  assign input_data         = input_data_q;
  assign training_data      = training_data_q;
  assign training_data_type = training_data_type_q;
  assign read_done          = read_done_q;
  assign run_done           = run_done_q;
  assign busy               = busy_q;
endmodule
